// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed FIR filter built around one signed multiplier
// and one accumulator. Each accepted sample costs TAPS MAC cycles plus one
// output cycle. Coefficients are runtime-writable while the block is idle.
// Optional feature macro: FIR_ROUND_EN (round half up before the output shift).
module fir_mac_seq #(
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int OW   = 8,
  parameter int TAPS = 4,
  parameter int FRAC = 2,
  parameter logic [TAPS*CW-1:0] COEF_INIT = {8'hFC, 8'h0F, 8'h0F, 8'hFC}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DW-1:0]     x_in,
  input  logic                     x_valid,
  output logic                     x_ready,
  input  logic                     c_we,
  input  logic [$clog2(TAPS)-1:0]  c_addr,
  input  logic signed [CW-1:0]     c_data,
  output logic signed [OW-1:0]     y_out,
  output logic                     y_valid
);

  localparam int KW = $clog2(TAPS);
  localparam int PW = DW + CW;
  localparam int AW = PW + KW;

  // Output clamp limits, expressed at the width of the rounded accumulator.
  localparam int YMAX_I = 2**(OW-1) - 1;
  localparam int YMIN_I = -(2**(OW-1));
  localparam logic signed [AW:0] YMAX = (AW+1)'(YMAX_I);
  localparam logic signed [AW:0] YMIN = (AW+1)'(YMIN_I);

`ifdef FIR_ROUND_EN
  // Half an output LSB; evaluates to zero when FRAC = 0.
  localparam int RND_I = (2**FRAC) / 2;
`else
  localparam int RND_I = 0;
`endif
  localparam logic signed [AW:0] RND = (AW+1)'(RND_I);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic signed [DW-1:0] tap_q  [TAPS];
  logic signed [CW-1:0] coef_q [TAPS];
  logic signed [AW-1:0] acc_q;
  logic [KW-1:0]        k_q;
  logic signed [OW-1:0] y_q;
  logic                 y_valid_q;

  logic                 accept;
  logic                 last_k;
  logic signed [PW-1:0] prod;

  // Scale the accumulator down to the output grid and clamp to OW bits.
  function automatic logic signed [OW-1:0] sat_ow(input logic signed [AW-1:0] a);
    logic signed [AW:0] r;
    r = (AW+1)'(a) + RND;
    r = r >>> FRAC;
    if (r > YMAX)      return YMAX[OW-1:0];
    else if (r < YMIN) return YMIN[OW-1:0];
    else               return r[OW-1:0];
  endfunction

  assign x_ready = (state_q == IDLE);
  assign accept  = x_valid & x_ready;
  assign last_k  = (k_q == KW'(TAPS-1));
  assign prod    = tap_q[k_q] * coef_q[k_q];
  assign y_out   = y_q;
  assign y_valid = y_valid_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: IDLE -> MAC (TAPS cycles) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = MAC;
      MAC:     if (last_k) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sample delay line, accumulator and tap index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) tap_q[i] <= '0;
      acc_q <= '0;
      k_q   <= '0;
    end else if (accept) begin
      for (int i = TAPS-1; i > 0; i--) tap_q[i] <= tap_q[i-1];
      tap_q[0] <= x_in;
      acc_q    <= '0;
      k_q      <= '0;
    end else if (state_q == MAC) begin
      acc_q <= acc_q + AW'(prod);
      k_q   <= k_q + KW'(1);
    end
  end

  // Coefficient bank; writes only land while idle, so an in-flight sum never
  // sees a mix of old and new coefficients.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) coef_q[i] <= COEF_INIT[i*CW +: CW];
    end else if (c_we && (state_q == IDLE) && (int'(c_addr) < TAPS)) begin
      coef_q[c_addr] <= c_data;
    end
  end

  // Output register and its one-cycle valid strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_valid_q <= (state_q == DONE);
      if (state_q == DONE) y_q <= sat_ow(acc_q);
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq: directed cases plus randomized traffic, checked every
// cycle against a sum-of-products reference model. Honours FIR_ROUND_EN.
module tb_fir_mac_seq;

  localparam int TAPS = 4;
  localparam int FRAC = 2;
  localparam int OW   = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [7:0] x_in;
  logic              x_valid;
  logic              x_ready;
  logic              c_we;
  logic [1:0]        c_addr;
  logic signed [7:0] c_data;
  logic signed [7:0] y_out;
  logic              y_valid;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int hist  [TAPS];
  int mcoef [TAPS];
  int m_cnt;
  int m_pend;
  int exp_y;
  int exp_yv;

  int n_acc, n_low;

  fir_mac_seq dut (
    .clk    (clk),
    .reset  (reset),
    .x_in   (x_in),
    .x_valid(x_valid),
    .x_ready(x_ready),
    .c_we   (c_we),
    .c_addr (c_addr),
    .c_data (c_data),
    .y_out  (y_out),
    .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int model_y();
    int s;
    s = 0;
    for (int i = 0; i < TAPS; i++) s += hist[i] * mcoef[i];
`ifdef FIR_ROUND_EN
    s += (2**FRAC) / 2;
`endif
    s = s >>> FRAC;
    if (s > 2**(OW-1) - 1) s = 2**(OW-1) - 1;
    if (s < -(2**(OW-1)))  s = -(2**(OW-1));
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) hist[i] = 0;
    mcoef  = '{-4, 15, 15, -4};
    m_cnt  = 0;
    m_pend = 0;
    exp_y  = 0;
    exp_yv = 0;
  endtask

  // Effect of one rising edge: idle accepts a sample, otherwise the busy
  // window counts down and the result appears as it closes.
  task automatic model_edge();
    exp_yv = 0;
    if (m_cnt == 0) begin
      if (c_we && int'(c_addr) < TAPS) mcoef[c_addr] = int'(c_data);
      if (x_valid) begin
        for (int i = TAPS-1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = int'(x_in);
        m_pend  = model_y();
        m_cnt   = TAPS + 1;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        exp_y  = m_pend;
        exp_yv = 1;
      end
    end
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk({tag, ".rdy"}, int'(x_ready), (m_cnt == 0) ? 1 : 0);
    chk({tag, ".vld"}, int'(y_valid), exp_yv);
    chk({tag, ".y"},   int'(y_out),   exp_y);
  endtask

  task automatic send(input int v, input string tag);
    x_in    = 8'(v);
    x_valid = 1'b1;
    cycle(tag);
    x_valid = 1'b0;
    repeat (TAPS + 1) cycle(tag);
  endtask

  task automatic wr(input int a, input int d);
    c_we   = 1'b1;
    c_addr = 2'(a);
    c_data = 8'(d);
    cycle("wr");
    c_we   = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    x_in    = '0;
    x_valid = 1'b0;
    c_we    = 1'b0;
    c_addr  = '0;
    c_data  = '0;
    model_reset();
    #12;
    chk("rst.rdy", int'(x_ready), 1);
    chk("rst.vld", int'(y_valid), 0);
    chk("rst.y",   int'(y_out),   0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Impulse response
    send(8, "imp"); chk("imp0", int'(y_out), -8);
    send(0, "imp"); chk("imp1", int'(y_out), 30);
    send(0, "imp"); chk("imp2", int'(y_out), 30);
    send(0, "imp"); chk("imp3", int'(y_out), -8);
    send(0, "imp"); chk("imp4", int'(y_out), 0);

    // Saturation at both rails
    repeat (5) send(127, "satp");
    chk("satp_end", int'(y_out), 127);
    repeat (5) send(-128, "satn");
    chk("satn_end", int'(y_out), -128);

    // Held x_valid: one acceptance per return to idle
    n_acc = 0;
    n_low = 0;
    x_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      x_in = 8'($urandom);
      if (x_ready) n_acc++;
      else         n_low++;
      cycle("hs");
    end
    x_valid = 1'b0;
    chk("hs_acc", n_acc, 3);
    chk("hs_low", n_low, 14);
    repeat (TAPS + 1) cycle("hs_drain");

    // Coefficient write while busy is dropped
    repeat (TAPS) send(0, "flush");
    x_in    = 8'sd8;
    x_valid = 1'b1;
    cycle("cwm");
    x_valid = 1'b0;
    c_we    = 1'b1;
    c_addr  = 2'd0;
    c_data  = 8'sd4;
    cycle("cwm");
    c_we    = 1'b0;
    repeat (TAPS) cycle("cwm");
    chk("cwm_ign", int'(y_out), -8);

    // Coefficient write while idle is honoured
    repeat (TAPS) send(0, "flush");
    wr(0, 4);
    send(8, "cwi");
    chk("cwi", int'(y_out), 8);

    // Write in the same cycle as acceptance applies to that sample
    c_we    = 1'b1;
    c_addr  = 2'd1;
    c_data  = 8'sd8;
    x_in    = 8'sd4;
    x_valid = 1'b1;
    cycle("same");
    c_we    = 1'b0;
    x_valid = 1'b0;
    repeat (TAPS + 1) cycle("same");
    chk("same", int'(y_out), 20);

    // Rounding of the output shift
    wr(0, 1); wr(1, 0); wr(2, 0); wr(3, 0);
    send(6, "rndp");
`ifdef FIR_ROUND_EN
    chk("rndp", int'(y_out), 2);
`else
    chk("rndp", int'(y_out), 1);
`endif
    send(-6, "rndn");
`ifdef FIR_ROUND_EN
    chk("rndn", int'(y_out), -1);
`else
    chk("rndn", int'(y_out), -2);
`endif

    // Randomized traffic with random coefficient writes
    for (int i = 0; i < 400; i++) begin
      x_valid = 1'($urandom_range(0, 1));
      x_in    = 8'($urandom);
      c_we    = ($urandom_range(0, 3) == 0);
      c_addr  = 2'($urandom);
      c_data  = 8'($urandom);
      cycle("rnd");
    end
    x_valid = 1'b0;
    c_we    = 1'b0;
    repeat (TAPS + 1) cycle("rnd_drain");

    // Reset in the middle of a computation
    wr(0, 4);
    x_in    = 8'sd8;
    x_valid = 1'b1;
    cycle("rm");
    x_valid = 1'b0;
    cycle("rm");
    cycle("rm");
    #3;
    reset = 1'b1;
    #1;
    chk("rm.rdy", int'(x_ready), 1);
    chk("rm.vld", int'(y_valid), 0);
    chk("rm.y",   int'(y_out),   0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) cycle("rm_post");
    send(8, "rm_imp");
    chk("rm_coef", int'(y_out), -8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
